dma_requester: RTL

DMA_REQUESTER -- requirements
Module: dma_requester

---
 rtl/dma_requester.sv | 114 +++++++++++
 1 files changed

// File: rtl/dma_requester.sv
// Four-channel DMA request generator: each channel counts acknowledged
// transfers in demand, single or block mode and reports terminal count or EOP abort.
module dma_requester #(
  parameter int LEN_W         = 8,
  parameter bit DREQ_ACT_LOW  = 1'b0,
  parameter bit DACK_ACT_HIGH = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             cfgWr,
  input  logic [1:0]       cfgCh,
  input  logic [LEN_W-1:0] cfgLen,
  input  logic [1:0]       cfgMode,
  input  logic [3:0]       start,
  input  logic [3:0]       DACK,
  input  logic             EOP_N,
  output logic [3:0]       DREQ,
  output logic [3:0]       busy,
  output logic [3:0]       done,
  output logic [3:0]       abort
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, BLK} state_t;

  localparam logic [LEN_W:0] REM_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};

  logic [3:0] ack;
  logic [3:0] dreq_vec;

  assign ack  = DACK_ACT_HIGH ? DACK : ~DACK;
  assign DREQ = DREQ_ACT_LOW ? ~dreq_vec : dreq_vec;

  for (genvar c = 0; c < 4; c++) begin : g_ch
    state_t           state_q, state_d;
    logic [LEN_W:0]   rem_q, rem_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_d, abort_d, counted;
    logic             dreq_q, busy_q, done_q, abort_q;

    // Terminal count takes priority over EOP so done and abort never coincide.
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      len_d   = len_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      counted = ack[c] && (state_q == REQ || state_q == BLK);

      if (cfgWr && cfgCh == 2'(c) && state_q == IDLE) begin
        len_d  = cfgLen;
        mode_d = cfgMode;
      end

      case (state_q)
        IDLE: begin
          if (start[c]) begin
            state_d = REQ;
            rem_d   = (len_q == '0) ? REM_FULL : {1'b0, len_q};
          end
        end
        GAP:     state_d = REQ;
        default: ;
      endcase

      if (counted && rem_q != '0) begin
        rem_d = rem_q - REM_ONE;
        if (rem_q == REM_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (!EOP_N) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (state_q == REQ) begin
          case (mode_q)
            2'b00:   state_d = REQ;
            2'b10:   state_d = BLK;
            default: state_d = GAP;
          endcase
        end
      end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        state_q <= IDLE;
        rem_q   <= '0;
        len_q   <= '0;
        mode_q  <= 2'b00;
        dreq_q  <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        abort_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
        len_q   <= len_d;
        mode_q  <= mode_d;
        dreq_q  <= (state_d == REQ);
        busy_q  <= (state_d != IDLE);
        done_q  <= done_d;
        abort_q <= abort_d;
      end
    end

    assign dreq_vec[c] = dreq_q;
    assign busy[c]     = busy_q;
    assign done[c]     = done_q;
    assign abort[c]    = abort_q;
  end

endmodule
